// File: rtl/i2c_reg_arbiter.sv
// Arbitrates an I2C slave port and a local host port onto one register bank; reg 0 is a read-only ID.
// One-cycle grant latency from a request seen in IDLE; requesters hold their level request until served.
module i2c_reg_arbiter #(
    parameter int         NUM_REGS    = 16,
    parameter logic [7:0] ID_VALUE    = 8'hA5,
    parameter int         ACK_TIMEOUT = 15_000
) (
    input  logic       i_sys_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_i2c_addr,
    input  logic       i_i2c_addr_load,
    input  logic       i_i2c_rd_req,
    output logic [7:0] o_i2c_rd_data,
    output logic       o_i2c_rd_valid,
    input  logic       i_i2c_rd_ack,
    input  logic [7:0] i_i2c_wr_data,
    input  logic       i_i2c_wr_valid,
    output logic       o_i2c_wr_ack,
    input  logic       i_host_req,
    input  logic       i_host_we,
    input  logic [7:0] i_host_addr,
    input  logic [7:0] i_host_wdata,
    output logic [7:0] o_host_rdata,
    output logic       o_host_done,
    output logic       o_err,
    output logic       o_busy
);

    localparam int         AW     = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
    localparam int         TW     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [8:0] NREGS9 = 9'(NUM_REGS);
    localparam logic [7:0] LAST   = 8'(NUM_REGS - 1);

    typedef enum logic [1:0] {IDLE, I2C_RD_HOLD, I2C_WR_ACK, HOST_ACK} state_t;

    state_t        state_q, state_d;
    logic [7:0]    ptr_q, ptr_d;
    logic [7:0]    bank_q [NUM_REGS];
    logic [7:0]    bank_d [NUM_REGS];
    logic [TW-1:0] tmo_q, tmo_d;
    logic          last_i2c_q, last_i2c_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          wr_ack_q, wr_ack_d;
    logic [7:0]    host_rdata_q, host_rdata_d;
    logic          host_done_q, host_done_d;
    logic          err_q, err_d;

    logic          i2c_pend, grant_i2c, grant_host;
    logic [7:0]    acc_addr, acc_wdata, acc_rdata, ptr_inc;
    logic          acc_in_range, acc_writable;

    assign i2c_pend   = i_i2c_rd_req | i_i2c_wr_valid;
    // On a tie, the side not served last wins.
    assign grant_i2c  = i2c_pend & (~i_host_req | ~last_i2c_q);
    assign grant_host = i_host_req & ~grant_i2c;

    assign acc_addr     = grant_host ? i_host_addr : ptr_q;
    assign acc_wdata    = grant_host ? i_host_wdata : i_i2c_wr_data;
    assign acc_in_range = ({1'b0, acc_addr} < NREGS9);
    assign acc_writable = acc_in_range && (acc_addr != 8'd0);
    assign acc_rdata    = (acc_addr == 8'd0) ? ID_VALUE :
                          (!acc_in_range)    ? 8'hFF    : bank_q[acc_addr[AW-1:0]];
    assign ptr_inc      = (ptr_q == LAST) ? 8'd0 : ptr_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        bank_d       = bank_q;
        tmo_d        = tmo_q;
        last_i2c_d   = last_i2c_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = rd_valid_q;
        host_rdata_d = host_rdata_q;
        wr_ack_d     = 1'b0;
        host_done_d  = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_i2c) begin
                    last_i2c_d = 1'b1;
                    // A pending write is served before a pending read.
                    if (i_i2c_wr_valid) begin
                        if (acc_writable) bank_d[acc_addr[AW-1:0]] = acc_wdata;
                        else              err_d = 1'b1;
                        wr_ack_d = 1'b1;
                        ptr_d    = ptr_inc;
                        state_d  = I2C_WR_ACK;
                    end else begin
                        rd_data_d  = acc_rdata;
                        rd_valid_d = 1'b1;
                        err_d      = !acc_in_range;
                        tmo_d      = TW'(ACK_TIMEOUT);
                        state_d    = I2C_RD_HOLD;
                    end
                end else if (grant_host) begin
                    last_i2c_d = 1'b0;
                    if (i_host_we) begin
                        if (acc_writable) bank_d[acc_addr[AW-1:0]] = acc_wdata;
                        else              err_d = 1'b1;
                    end else begin
                        host_rdata_d = acc_rdata;
                        err_d        = !acc_in_range;
                    end
                    host_done_d = 1'b1;
                    state_d     = HOST_ACK;
                end
            end
            I2C_RD_HOLD: begin
                if (i_i2c_rd_ack) begin
                    rd_valid_d = 1'b0;
                    ptr_d      = ptr_inc;
                    state_d    = IDLE;
                end else if (tmo_q <= TW'(1)) begin
                    // Abandoned read: the pointer stays put so the master can retry.
                    rd_valid_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = IDLE;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            I2C_WR_ACK: state_d = IDLE;
            HOST_ACK:   state_d = IDLE;
            default:    state_d = IDLE;
        endcase

        if (i_i2c_addr_load) ptr_d = i_i2c_addr;
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= 8'd0;
            tmo_q        <= '0;
            last_i2c_q   <= 1'b0;
            rd_data_q    <= 8'd0;
            rd_valid_q   <= 1'b0;
            wr_ack_q     <= 1'b0;
            host_rdata_q <= 8'd0;
            host_done_q  <= 1'b0;
            err_q        <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= 8'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            tmo_q        <= tmo_d;
            last_i2c_q   <= last_i2c_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            wr_ack_q     <= wr_ack_d;
            host_rdata_q <= host_rdata_d;
            host_done_q  <= host_done_d;
            err_q        <= err_d;
            for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= bank_d[i];
        end
    end

    assign o_i2c_rd_data  = rd_data_q;
    assign o_i2c_rd_valid = rd_valid_q;
    assign o_i2c_wr_ack   = wr_ack_q;
    assign o_host_rdata   = host_rdata_q;
    assign o_host_done    = host_done_q;
    assign o_err          = err_q;
    assign o_busy         = (state_q != IDLE);

endmodule
